// File: rtl/uart_pkg.sv
// Shared UART types and frame constants for the receiver and transmitter.
package uart_pkg;

  // Serial frame line levels
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Receiver state
  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_RECOVER = 3'd4
  } rx_state_t;

  // Transmitter state
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Total serial bits in one frame: start + data + stop
  function automatic int frame_bits(input int bit_n);
    return bit_n + 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Metastability chain; reset value matches the idle level of the line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, BIT_N data bits LSB first, 1 stop, no parity.
// Start bit is confirmed at its midpoint; each following bit is sampled
// one full bit period later, i.e. near its own midpoint.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter int BIT_N       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_i,
  output logic [BIT_N-1:0] data_o,
  output logic             data_vld_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = $clog2(BIT_N) + 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_N - 1);

  logic             rx_s;
  rx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [BIT_N-1:0] shift_q;
  logic [BIT_N-1:0] data_q;
  logic             vld_q;
  logic             ferr_q;
  logic             busy_q;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_i),
    .q   (rx_s)
  );

  // Frame FSM, bit timing, data capture and registered output pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (rx_s == START_BIT) begin
            state_q <= RX_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches
        RX_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (rx_s == START_BIT) begin
              state_q <= RX_DATA;
              idx_q   <= '0;
            end else begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        RX_DATA: begin
          if (cnt_q == CNT_END) begin
            cnt_q <= '0;
            for (int i = 0; i < BIT_N; i++) begin
              if (idx_q == IDX_W'(i)) shift_q[i] <= rx_s;
            end
            idx_q <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Leave at mid stop bit so a back-to-back start edge is not missed
        RX_STOP: begin
          if (cnt_q == CNT_END) begin
            cnt_q <= '0;
            if (rx_s == STOP_BIT) begin
              data_q  <= shift_q;
              vld_q   <= 1'b1;
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= RX_RECOVER;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Wait out a break so a low line yields a single error
        RX_RECOVER: begin
          if (rx_s == STOP_BIT) begin
            state_q <= RX_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign data_vld_o  = vld_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = busy_q;

endmodule
